// File: rtl/lut_prog_pkg.sv
// Shared definitions for the programmable lookup table: FSM state
// encodings and the legal range of the input-count parameter.
package lut_prog_pkg;

    // Controller states. UNCONF holds no usable table, LOAD is shifting the
    // truth table in, READY serves lookups.
    typedef enum logic [1:0] {
        ST_UNCONF = 2'd0,
        ST_LOAD   = 2'd1,
        ST_READY  = 2'd2
    } lut_state_t;

    // Supported number of LUT inputs.
    localparam int N_IN_MIN = 1;
    localparam int N_IN_MAX = 6;

endpackage

// File: rtl/lut_table.sv
// Truth-table storage: one write port driven by the load sequencer and a
// purely combinational read mux addressed by the lookup vector.
module lut_table
    import lut_prog_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [N_IN-1:0] waddr,
    input  logic            wdata,
    input  logic [N_IN-1:0] raddr,
    output logic            rdata
);

    localparam int DEPTH = 1 << N_IN;

    logic [DEPTH-1:0] table_q;

    // Table bits are written one at a time during a load; reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            table_q <= '0;
        end else if (we) begin
            table_q[waddr] <= wdata;
        end
    end

    assign rdata = table_q[raddr];

endmodule

// File: rtl/lut_prog.sv
// Programmable N-input LUT. The truth table is loaded serially (address 0
// first) under a three-state controller, after which each qualified lookup
// returns table[X] one cycle later with a valid flag.
module lut_prog
    import lut_prog_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_busy,
    output logic            cfg_done,
    input  logic            in_valid,
    input  logic [N_IN-1:0] X,
    output logic            F,
    output logic            out_valid
);

    localparam int DEPTH = 1 << N_IN;
    localparam logic [N_IN:0] LAST_ADDR = (N_IN+1)'(DEPTH - 1);

    lut_state_t    state_q, state_d;
    logic [N_IN:0] cnt_q, cnt_d;
    logic          f_q, f_d;
    logic          out_valid_q, out_valid_d;
    logic          done_q, done_d;
    logic          tbl_we;
    logic          tbl_rdata;

    lut_table #(.N_IN(N_IN)) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (cnt_q[N_IN-1:0]),
        .wdata (cfg_bit),
        .raddr (X),
        .rdata (tbl_rdata)
    );

    // State, load counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_UNCONF;
            cnt_q       <= '0;
            f_q         <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f_q         <= f_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic. A start request always wins over a coincident config
    // bit or lookup, and the counter leaves LOAD at the last address so it
    // never wraps; a half-written table is therefore never read.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f_d         = f_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        tbl_we      = 1'b0;
        case (state_q)
            ST_UNCONF: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (cfg_start) begin
                    cnt_d = '0;
                end else if (cfg_valid) begin
                    tbl_we = 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (cfg_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end else if (in_valid) begin
                    f_d         = tbl_rdata;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_UNCONF;
                cnt_d   = '0;
            end
        endcase
    end

    assign cfg_busy  = (state_q == ST_LOAD);
    assign cfg_done  = done_q;
    assign F         = f_q;
    assign out_valid = out_valid_q;

endmodule
